// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared types and constants for the button event controller.
// Event codes, per-button FSM states and the hold counter width live here so
// the per-button sequencer and the arbiter agree on them.
package btn_evt_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } btn_state_t;

endpackage

// File: rtl/btn_evt_fsm.sv
// btn_evt_fsm: per-button sequencer turning a debounced level into PRESS,
// RELEASE, LONG and (optionally) REPEAT events, with a one-deep pending slot
// that the top-level arbiter drains through the grant input.
// Build option: define BTN_EVT_REPEAT_EN to emit REPEAT events while HELD;
// without it HELD simply waits for release and REPEAT_MS has no effect.
module btn_evt_fsm #(
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic       btn,
    input  logic       grant,
    output logic       pend_vld,
    output logic [1:0] pend_type,
    output logic       drop
);
    import btn_evt_pkg::*;

`ifdef BTN_EVT_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    // Terminal counts: the counter restarts at 0 on entry, so the match value
    // is one less than the desired interval.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             queue;
    evt_type_t        queue_type;
    logic             pend_vld_nxt;
    evt_type_t        pend_type_nxt;

    // State, hold counter and pending slot registers.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend_vld  <= 1'b0;
            pend_type <= EVT_PRESS;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_type <= pend_type_nxt;
        end
    end

    // Next state, counter, event generation and slot write/drop decision.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        queue         = 1'b0;
        queue_type    = EVT_PRESS;
        pend_vld_nxt  = pend_vld;
        pend_type_nxt = evt_type_t'(pend_type);
        drop          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (btn) begin
                    state_nxt  = ST_PRESSED;
                    cnt_nxt    = '0;
                    queue      = 1'b1;
                    queue_type = EVT_PRESS;
                end
            end
            ST_PRESSED: begin
                if (!btn) begin
                    state_nxt  = ST_IDLE;
                    queue      = 1'b1;
                    queue_type = EVT_RELEASE;
                end else if (cnt == LONG_LAST) begin
                    state_nxt  = ST_HELD;
                    cnt_nxt    = '0;
                    queue      = 1'b1;
                    queue_type = EVT_LONG;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                // Release wins over a repeat match landing in the same cycle.
                if (!btn) begin
                    state_nxt  = ST_IDLE;
                    queue      = 1'b1;
                    queue_type = EVT_RELEASE;
                end else if (REPEAT_EN) begin
                    if (cnt == REPEAT_LAST) begin
                        cnt_nxt    = '0;
                        queue      = 1'b1;
                        queue_type = EVT_REPEAT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A grant empties the slot this cycle, so a new event may refill it.
        if (grant) begin
            pend_vld_nxt = 1'b0;
        end
        if (queue) begin
            if (!pend_vld || grant) begin
                pend_vld_nxt  = 1'b1;
                pend_type_nxt = queue_type;
            end else begin
                drop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: collects press/release/long/repeat events from NUM_BTN
// debounced buttons and serialises them onto one valid/ready event port with
// a round-robin arbiter. Runs on the 1 kHz clock, one cycle per millisecond.
// Build option: define BTN_EVT_REPEAT_EN to enable auto-repeat events.
module btn_event_ctrl #(
    parameter int NUM_BTN       = 4,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic               clk_1khz,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_db,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [2:0]         evt_btn,
    output logic [1:0]         evt_type,
    output logic               evt_overflow
);
    import btn_evt_pkg::*;

    logic [NUM_BTN-1:0] pend_vld;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] drop;
    logic [1:0]         pend_type [NUM_BTN];
    logic [2:0]         last_grant;
    logic [2:0]         sel;
    logic [1:0]         sel_type;
    logic               found;
    logic               load;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_evt_fsm #(
            .LONG_PRESS_MS(LONG_PRESS_MS),
            .REPEAT_MS    (REPEAT_MS)
        ) u_fsm (
            .clk_1khz (clk_1khz),
            .rst      (rst),
            .btn      (btn_db[i]),
            .grant    (grant[i]),
            .pend_vld (pend_vld[i]),
            .pend_type(pend_type[i]),
            .drop     (drop[i])
        );
    end

    // The output register may take a new event when empty or being consumed.
    assign load = !evt_valid || evt_ready;

    // Round-robin search for the first pending slot after the last winner.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_type = EVT_PRESS;
        for (int k = 1; k <= NUM_BTN; k++) begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (!found && pend_vld[b] && (b == (int'(last_grant) + k) % NUM_BTN)) begin
                    found    = 1'b1;
                    sel      = 3'(b);
                    sel_type = pend_type[b];
                end
            end
        end
    end

    // One-hot grant back to the winning slot so it clears (or refills).
    always_comb begin
        grant = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            grant[b] = load && found && (sel == 3'(b));
        end
    end

    // Output event register and round-robin pointer; held while stalled.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_btn    <= '0;
            evt_type   <= EVT_PRESS;
            last_grant <= 3'(NUM_BTN - 1);
        end else if (load) begin
            evt_valid <= found;
            if (found) begin
                evt_btn    <= sel;
                evt_type   <= sel_type;
                last_grant <= sel;
            end
        end
    end

    // Sticky flag raised whenever any button had to discard an event.
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            evt_overflow <= 1'b0;
        end else if (|drop) begin
            evt_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed scenarios plus randomized button activity for
// btn_event_ctrl, checked cycle by cycle against an event-level reference
// model (press age in cycles, one-slot mailboxes, round-robin pick).
module tb_btn_event_ctrl;

    localparam int NB = 4;
    localparam int LP = 1000;
    localparam int RP = 200;

`ifdef BTN_EVT_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_REL   = 2'b01;
    localparam logic [1:0] T_LONG  = 2'b10;
    localparam logic [1:0] T_REP   = 2'b11;

    logic          clk_1khz = 1'b0;
    logic          rst      = 1'b1;
    logic [NB-1:0] btn_db   = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [2:0]    evt_btn;
    logic [1:0]    evt_type;
    logic          evt_overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    bit         m_lvl [NB];
    int         m_age [NB];
    bit         m_pv  [NB];
    logic [1:0] m_pt  [NB];
    bit         m_valid;
    logic [2:0] m_btn;
    logic [1:0] m_type;
    int         m_last;
    bit         m_ovf;

    always #5 clk_1khz = ~clk_1khz;

    btn_event_ctrl #(
        .NUM_BTN      (NB),
        .LONG_PRESS_MS(LP),
        .REPEAT_MS    (RP)
    ) dut (
        .clk_1khz    (clk_1khz),
        .rst         (rst),
        .btn_db      (btn_db),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_btn     (evt_btn),
        .evt_type    (evt_type),
        .evt_overflow(evt_overflow)
    );

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            m_lvl[b] = 1'b0;
            m_age[b] = 0;
            m_pv[b]  = 1'b0;
            m_pt[b]  = T_PRESS;
        end
        m_valid = 1'b0;
        m_btn   = '0;
        m_type  = T_PRESS;
        m_last  = NB - 1;
        m_ovf   = 1'b0;
    endfunction

    // One clock edge of the event-level model, using the inputs at the edge.
    function automatic void model_step();
        bit         load;
        int         g;
        int         idx;
        logic [1:0] gt;
        bit         ev;
        logic [1:0] et;
        load = !m_valid || evt_ready;
        g    = -1;
        gt   = T_PRESS;
        if (load) begin
            for (int k = 1; k <= NB; k++) begin
                idx = (m_last + k) % NB;
                if (g < 0 && m_pv[idx]) begin
                    g  = idx;
                    gt = m_pt[idx];
                end
            end
        end
        for (int b = 0; b < NB; b++) begin
            ev = 1'b0;
            et = T_PRESS;
            if (btn_db[b] && !m_lvl[b]) begin
                ev = 1'b1; et = T_PRESS; m_age[b] = 0;
            end else if (!btn_db[b] && m_lvl[b]) begin
                ev = 1'b1; et = T_REL;
            end else if (btn_db[b]) begin
                m_age[b]++;
                if (m_age[b] == LP) begin
                    ev = 1'b1; et = T_LONG;
                end else if (REP_ON && m_age[b] > LP && ((m_age[b] - LP) % RP) == 0) begin
                    ev = 1'b1; et = T_REP;
                end
            end
            m_lvl[b] = btn_db[b];
            if (g == b) m_pv[b] = 1'b0;
            if (ev) begin
                if (!m_pv[b]) begin
                    m_pv[b] = 1'b1;
                    m_pt[b] = et;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (load) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_btn  = 3'(g);
                m_type = gt;
                m_last = g;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk_1khz);
        if (rst) model_reset();
        else     model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", evt_valid); end
            checks++;
            if (evt_btn !== 3'd0) begin errors++; $display("FAIL reset_btn got=%0d want=0", evt_btn); end
            checks++;
            if (evt_type !== 2'd0) begin errors++; $display("FAIL reset_type got=%0d want=0", evt_type); end
            checks++;
            if (evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", evt_overflow); end
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b want=0", evt_valid); end
        end
    endtask

    task automatic test_short_press();
        int nval;
        nval = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            btn_db[0] = (i < 50);
            tick();
            if (evt_valid) nval++;
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL short_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
            if (i == 1) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd0, T_PRESS}) begin
                    errors++; $display("FAIL short_press got=%b want=%b", {evt_valid, evt_btn, evt_type}, {1'b1, 3'd0, T_PRESS});
                end
            end
            if (i == 51) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd0, T_REL}) begin
                    errors++; $display("FAIL short_release got=%b want=%b", {evt_valid, evt_btn, evt_type}, {1'b1, 3'd0, T_REL});
                end
            end
        end
        checks++;
        if (nval != 2) begin errors++; $display("FAIL short_count got=%0d want=2", nval); end
    endtask

    task automatic test_long_hold();
        int         ev_i[$];
        logic [1:0] ev_t[$];
        logic [2:0] ev_b[$];
        int         ex_i[$];
        logic [1:0] ex_t[$];
        int         n;
        evt_ready = 1'b1;
        for (int i = 0; i < 1510; i++) begin
            btn_db[1] = (i < 1500);
            tick();
            if (evt_valid) begin ev_i.push_back(i); ev_t.push_back(evt_type); ev_b.push_back(evt_btn); end
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL long_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
        end
        ex_i.push_back(1);    ex_t.push_back(T_PRESS);
        ex_i.push_back(1001); ex_t.push_back(T_LONG);
        if (REP_ON) begin
            ex_i.push_back(1201); ex_t.push_back(T_REP);
            ex_i.push_back(1401); ex_t.push_back(T_REP);
        end
        ex_i.push_back(1501); ex_t.push_back(T_REL);
        checks++;
        if (ev_i.size() != ex_i.size()) begin
            errors++; $display("FAIL long_count got=%0d want=%0d", ev_i.size(), ex_i.size());
        end
        n = (ev_i.size() < ex_i.size()) ? ev_i.size() : ex_i.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ev_i[k] != ex_i[k] || ev_t[k] !== ex_t[k] || ev_b[k] !== 3'd1) begin
                errors++;
                $display("FAIL long_event%0d got t=%0d type=%0d btn=%0d want t=%0d type=%0d btn=1",
                         k, ev_i[k], ev_t[k], ev_b[k], ex_i[k], ex_t[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            btn_db = (i < 6) ? 4'hF : 4'h0;
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL simul_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'(i - 1), T_PRESS}) begin
                    errors++; $display("FAIL simul_press%0d got=%b want=%b", i - 1, {evt_valid, evt_btn, evt_type}, {1'b1, 3'(i - 1), T_PRESS});
                end
            end
            if (i == 5) begin
                checks++;
                if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_gap got=%b want=0", evt_valid); end
            end
            if (i >= 7 && i <= 10) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'(i - 7), T_REL}) begin
                    errors++; $display("FAIL simul_release%0d got=%b want=%b", i - 7, {evt_valid, evt_btn, evt_type}, {1'b1, 3'(i - 7), T_REL});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 18; i++) begin
            evt_ready = (i >= 12);
            btn_db[2] = (i < 5) || (i >= 10 && i < 14);
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL bp_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
            if (i >= 1 && i <= 11) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd2, T_PRESS}) begin
                    errors++; $display("FAIL bp_hold i=%0d got=%b want=%b", i, {evt_valid, evt_btn, evt_type}, {1'b1, 3'd2, T_PRESS});
                end
                checks++;
                if (evt_overflow !== (i >= 10)) begin
                    errors++; $display("FAIL bp_ovf i=%0d got=%b want=%b", i, evt_overflow, (i >= 10));
                end
            end
            if (i == 12) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd2, T_REL}) begin
                    errors++; $display("FAIL bp_release got=%b want=%b", {evt_valid, evt_btn, evt_type}, {1'b1, 3'd2, T_REL});
                end
            end
            if (i == 13) begin
                checks++;
                if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b want=0", evt_valid); end
            end
        end
    endtask

    task automatic test_reset_during_hold();
        evt_ready = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            btn_db[3] = 1'b1;
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL rhold_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
        end
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== 7'd0) begin
                errors++; $display("FAIL rhold_in_reset got=%b want=0000000", {evt_valid, evt_btn, evt_type, evt_overflow});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 1010; i++) begin
            btn_db[3] = (i < 1005);
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL rhold_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
            if (i == 1) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd3, T_PRESS}) begin
                    errors++; $display("FAIL rhold_press got=%b want=%b", {evt_valid, evt_btn, evt_type}, {1'b1, 3'd3, T_PRESS});
                end
            end
            if (i == 1001) begin
                checks++;
                if ({evt_valid, evt_btn, evt_type} !== {1'b1, 3'd3, T_LONG}) begin
                    errors++; $display("FAIL rhold_long got=%b want=%b", {evt_valid, evt_btn, evt_type}, {1'b1, 3'd3, T_LONG});
                end
            end
        end
    endtask

    task automatic test_random();
        int rem [NB];
        for (int b = 0; b < NB; b++) rem[b] = $urandom_range(1, 30);
        btn_db = '0;
        for (int i = 0; i < 12000 && errors < 30; i++) begin
            for (int b = 0; b < NB; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    btn_db[b] = ~btn_db[b];
                    if (btn_db[b]) begin
                        case ($urandom_range(0, 5))
                            0, 1, 2: rem[b] = $urandom_range(1, 40);
                            3:       rem[b] = $urandom_range(LP - 3, LP + 3);
                            4:       rem[b] = $urandom_range(LP + RP - 3, LP + RP + 3);
                            default: rem[b] = $urandom_range(1, 300);
                        endcase
                    end else begin
                        rem[b] = $urandom_range(1, 60);
                    end
                end
            end
            evt_ready = ($urandom_range(0, 9) < 7);
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
        end
        btn_db    = '0;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({evt_valid, evt_btn, evt_type, evt_overflow} !== {m_valid, m_btn, m_type, m_ovf}) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%b want=%b", cyc,
                         {evt_valid, evt_btn, evt_type, evt_overflow}, {m_valid, m_btn, m_type, m_ovf});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_press();
        test_long_hold();
        test_simultaneous();
        test_backpressure();
        test_reset_during_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

- Sequences the debounced button levels of up to `NUM_BTN` debouncer instances into a single stream of discrete events: press, release, long-press and auto-repeat.
- Arbitrates the buttons onto one valid/ready event port using round-robin.
- Sits between the per-button debouncers and the application FSM on the 1 kHz clock domain; one cycle = 1 ms.

## Interface
Parameters:
- `NUM_BTN`, 4 — number of buttons, 1..8.
- `LONG_PRESS_MS`, 1000 — hold cycles before a LONG event, 2..65535.
- `REPEAT_MS`, 200 — cycles between REPEAT events while held, 2..65535.

Ports:
- `clk_1khz` in, 1 — the only clock.
- `rst` in, 1 — asynchronous, active-high reset.
- `btn_db` in, `NUM_BTN` — debounced levels from the debouncers; 1 = pressed.
- `evt_valid` out, 1 — an event is presented.
- `evt_ready` in, 1 — consumer accepts; transfer occurs when `evt_valid && evt_ready`.
- `evt_btn` out, 3 — index of the source button.
- `evt_type` out, 2 — event code.
- `evt_overflow` out, 1 — sticky; set when any event is dropped.

## Operation
Per-button FSM, with a 16-bit hold counter `cnt`:
- IDLE, `btn_db`=1: go to PRESSED, `cnt`=0, queue PRESS.
- PRESSED, `btn_db`=0: go to IDLE, queue RELEASE.
- PRESSED, otherwise: `cnt`++. When `cnt`==`LONG_PRESS_MS`-1: go to HELD, `cnt`=0, queue LONG.
- HELD, `btn_db`=0: go to IDLE, queue RELEASE. Release has priority over any counter match in the same cycle.
- HELD, otherwise: see Configuration.

Pending slots:
- Each button has one slot: `pend_vld` plus `pend_type`.
- A queued event is written to the slot if the slot is empty, or if the slot is being granted to the output in the same cycle.
- Otherwise the new event is dropped, the slot keeps its old event, and `evt_overflow` is set. `evt_overflow` clears only on reset.

Output register:
- Loads when `!evt_valid || evt_ready`.
- The arbiter then grants the first slot with `pend_vld` set, searching round-robin from `last_grant+1` with modulo `NUM_BTN` wrap.
- On a grant, `evt_valid`=1, `evt_btn`/`evt_type` take the slot contents, the slot is cleared, and `last_grant` is updated.
- If nothing is pending, `evt_valid`=0.
- While `evt_valid && !evt_ready`, `evt_btn` and `evt_type` are held stable.

## Timing
- Reset values: `evt_valid`=0, `evt_btn`=0, `evt_type`=0, `evt_overflow`=0.
- Reset also forces all FSMs to IDLE, clears all slots, and sets `last_grant`=`NUM_BTN`-1, so the first search starts at button 0.
- Latency: a `btn_db` edge sampled at edge N writes the slot at N; `evt_valid` is asserted after edge N+1 when the output is free.
- Throughput: one event per cycle with `evt_ready` tied high.
- LONG fires exactly `LONG_PRESS_MS` cycles after PRESS is queued. REPEAT events follow at `REPEAT_MS` intervals.
- Reset mid-operation: in-flight and pending events are lost. A button still held at reset release produces a fresh PRESS.

## Configuration
Macro `BTN_EVT_REPEAT_EN`:
- Defined: in HELD, `cnt`++; when `cnt`==`REPEAT_MS`-1, queue REPEAT and set `cnt`=0.
- Undefined: HELD is static until release; code 2'b11 is never emitted and the `REPEAT_MS` parameter is ignored.

## Structure
- Package `btn_evt_pkg` holds:
  - the `evt_type_t` enum: PRESS=2'b00, RELEASE=2'b01, LONG=2'b10, REPEAT=2'b11;
  - the FSM state enum: IDLE, PRESSED, HELD;
  - the counter width constant, 16.
- Sub-module `btn_evt_fsm`:
  - one instance per button, built with a generate loop;
  - contains the FSM, the counter and the pending slot;
  - exposes `pend_vld`, `pend_type` and a `grant` input.
- The arbiter and output register stay in the top level.

## Test plan
- **Short press:** `evt_ready`=1; btn0 high 50 cycles then low → PRESS btn0 two cycles after the rise, RELEASE btn0 two cycles after the fall, no LONG.
- **Long hold:** btn1 held 1500 cycles.
  - Macro defined → PRESS, then LONG +1000, REPEAT +1200 and +1400, then RELEASE.
  - Macro undefined → PRESS, LONG, RELEASE only.
- **Simultaneous press:** btn0..3 rise in the same cycle after reset, ready=1 → PRESS events for btn 0, 1, 2, 3 on four consecutive cycles. A second burst starts at btn0 again, because the pointer has wrapped.
- **Backpressure and overflow:** `evt_ready`=0; btn2 rises at t, falls at t+5, rises at t+10.
  - Output holds PRESS btn2 stable.
  - The slot holds RELEASE.
  - The second PRESS is dropped; `evt_overflow`=1 after edge t+10.
  - With ready=1 afterwards → RELEASE is delivered, then the stream is idle.
- **Reset during hold:** `rst` pulsed while btn3 is in HELD and stays pressed → all outputs 0 during reset. After release: PRESS btn3 after two cycles, and LONG `LONG_PRESS_MS` cycles later.
